// File: rtl/wb_arbiter.sv
// Writeback arbiter: the ALU always wins the register-file write port, LSU results
// queue in a small FIFO and drain when the ALU is idle, and decode can read pending results.
module wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_valid,
   input  logic [4:0]                   alu_rd,
   input  logic [XLEN-1:0]              alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [4:0]                   lsu_rd,
   input  logic [XLEN-1:0]              lsu_data,
   output logic                         wr_en,
   output logic [4:0]                   addr_d,
   output logic [XLEN-1:0]              data_d,
   input  logic [4:0]                   query_addr,
   output logic                         query_hit,
   output logic [XLEN-1:0]              query_data,
   output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   logic              ent_v_q    [DEPTH];
   logic              ent_v_d    [DEPTH];
   logic [4:0]        ent_rd_q   [DEPTH];
   logic [4:0]        ent_rd_d   [DEPTH];
   logic [XLEN-1:0]   ent_data_q [DEPTH];
   logic [XLEN-1:0]   ent_data_d [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              out_wr_q, out_wr_d;
   logic [4:0]        out_addr_q, out_addr_d;
   logic [XLEN-1:0]   out_data_q, out_data_d;
   logic              alu_wr_s, push_s, pop_s;
   int                best_age_s, age_s;

   assign lsu_ready   = !rst && (count_q < CW'(DEPTH));
   assign alu_wr_s    = alu_valid && (alu_rd != 5'd0);
   assign push_s      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
   assign pop_s       = !alu_wr_s && (count_q != {CW{1'b0}});
   assign wr_en       = out_wr_q;
   assign addr_d      = out_addr_q;
   assign data_d      = out_data_q;
   assign pending_cnt = count_q;

   // Next FIFO contents, pointers and write-port selection.
   always_comb begin
      ent_rd_d   = ent_rd_q;
      ent_data_d = ent_data_q;
      ent_v_d    = ent_v_q;
      head_d     = head_q;
      tail_d     = tail_q;
      out_wr_d   = 1'b0;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      // A younger ALU write to the same rd makes every buffered value for it stale.
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_wr_s && (ent_rd_q[i] == alu_rd)) begin
            ent_v_d[i] = 1'b0;
         end else begin
            ent_v_d[i] = ent_v_q[i];
         end
      end
      if (alu_wr_s) begin
         out_wr_d   = 1'b1;
         out_addr_d = alu_rd;
         out_data_d = alu_data;
      end else if (pop_s) begin
         out_wr_d        = ent_v_q[head_q];
         ent_v_d[head_q] = 1'b0;
         head_d          = ptr_inc(head_q);
         if (ent_v_q[head_q]) begin
            out_addr_d = ent_rd_q[head_q];
            out_data_d = ent_data_q[head_q];
         end else begin
            out_addr_d = out_addr_q;
            out_data_d = out_data_q;
         end
      end else begin
         out_wr_d = 1'b0;
      end
      if (push_s) begin
         ent_v_d[tail_q]    = !(alu_wr_s && (lsu_rd == alu_rd));
         ent_rd_d[tail_q]   = lsu_rd;
         ent_data_d[tail_q] = lsu_data;
         tail_d             = ptr_inc(tail_q);
      end else begin
         tail_d = tail_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
   end

   // Forwarding: newest valid buffered entry first, then the output register.
   always_comb begin
      query_hit  = 1'b0;
      query_data = {XLEN{1'b0}};
      best_age_s = -1;
      age_s      = 0;
      for (int i = 0; i < DEPTH; i++) begin
         age_s = (i + DEPTH - int'(head_q)) % DEPTH;
         if (ent_v_q[i] && (ent_rd_q[i] == query_addr) && (age_s > best_age_s)) begin
            best_age_s = age_s;
            query_hit  = 1'b1;
            query_data = ent_data_q[i];
         end else begin
            best_age_s = best_age_s;
         end
      end
      if (query_addr == 5'd0) begin
         query_hit  = 1'b0;
         query_data = {XLEN{1'b0}};
      end else if (!query_hit && out_wr_q && (out_addr_q == query_addr)) begin
         query_hit  = 1'b1;
         query_data = out_data_q;
      end else begin
         query_hit = query_hit;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_v_q[i]    <= 1'b0;
            ent_rd_q[i]   <= 5'd0;
            ent_data_q[i] <= {XLEN{1'b0}};
         end
         head_q     <= {PW{1'b0}};
         tail_q     <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         out_wr_q   <= 1'b0;
         out_addr_q <= 5'd0;
         out_data_q <= {XLEN{1'b0}};
      end else begin
         ent_v_q    <= ent_v_d;
         ent_rd_q   <= ent_rd_d;
         ent_data_q <= ent_data_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         out_wr_q   <= out_wr_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all checked
// against a queue-based model of the writeback port.
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic        v;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        alu_valid, lsu_valid, lsu_ready;
   logic [4:0]                  alu_rd, lsu_rd, query_addr, addr_d;
   logic [XLEN-1:0]             alu_data, lsu_data, data_d, query_data;
   logic                        wr_en, query_hit;
   logic [$clog2(DEPTH+1)-1:0]  pending_cnt;

   ent_t        mq[$];
   logic        m_wr;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          n_vec = 0;
   int          n_err = 0;

   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .wr_en(wr_en), .addr_d(addr_d), .data_d(data_d),
      .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data),
      .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Check current outputs against the model, advance the model, then clock once.
   task automatic tick();
      logic        exp_ready, exp_hit, alu_wr, accept;
      logic [31:0] exp_qd;
      ent_t        e;
      #1;
      exp_ready = !rst && (mq.size() < DEPTH);
      exp_hit   = 1'b0;
      exp_qd    = 32'd0;
      if (query_addr != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!exp_hit && mq[i].v && mq[i].rd == query_addr) begin
               exp_hit = 1'b1;
               exp_qd  = mq[i].data;
            end
         end
         if (!exp_hit && m_wr && m_addr == query_addr) begin
            exp_hit = 1'b1;
            exp_qd  = m_data;
         end
      end
      check("lsu_ready", 64'(lsu_ready), 64'(exp_ready));
      check("wr_en", 64'(wr_en), 64'(m_wr));
      check("addr_d", 64'(addr_d), 64'(m_addr));
      check("data_d", 64'(data_d), 64'(m_data));
      check("pending_cnt", 64'(pending_cnt), 64'(mq.size()));
      check("query_hit", 64'(query_hit), 64'(exp_hit));
      check("query_data", 64'(query_data), 64'(exp_qd));

      if (rst) begin
         mq.delete();
         m_wr   = 1'b0;
         m_addr = 5'd0;
         m_data = 32'd0;
      end else begin
         alu_wr = alu_valid && alu_rd != 5'd0;
         accept = lsu_valid && exp_ready && lsu_rd != 5'd0;
         if (alu_wr) begin
            m_wr   = 1'b1;
            m_addr = alu_rd;
            m_data = alu_data;
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].v = 1'b0;
         end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_wr = e.v;
            if (e.v) begin
               m_addr = e.rd;
               m_data = e.data;
            end
         end else begin
            m_wr = 1'b0;
         end
         if (accept) begin
            e.v    = !(alu_wr && lsu_rd == alu_rd);
            e.rd   = lsu_rd;
            e.data = lsu_data;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] qa);
      rst        = r;
      alu_valid  = av;
      alu_rd     = ard;
      alu_data   = ad;
      lsu_valid  = lv;
      lsu_rd     = lrd;
      lsu_data   = ld;
      query_addr = qa;
      tick();
   endtask

   initial begin
      rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0; query_addr = 5'd0;
      m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      @(negedge clk);
      @(negedge clk);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

      // ALU write and its one-cycle latency
      step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd5);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);

      // single LSU result through an empty FIFO
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAA, 5'd3);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3);

      // ALU hogs the port while the FIFO fills, then drains in order
      for (int k = 1; k <= 4; k++)
         step(1'b0, 1'b1, 5'd10, 32'(k), 1'b1, 5'(k > 3 ? 3 : k), 32'(16 * k), 5'd2);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1);

      // WAW kill of a buffered entry
      step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h70, 5'd7);
      step(1'b0, 1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0, 5'd7);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);

      // same-cycle kill, then rd=0 on both sources
      step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h40, 5'd4);
      step(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h50, 5'd4);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4);

      // reset in the middle of a drain
      step(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'h80, 5'd8);
      step(1'b0, 1'b1, 5'd2, 32'h3, 1'b1, 5'd9, 32'h90, 5'd9);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
      step(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd10, 32'hA0, 5'd9);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);

      // random traffic over a small register window to force collisions
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
